// File: rtl/opl3_slot_scheduler.sv
// rtl/opl3_slot_scheduler.sv - time-division slot scheduler for the shared OPL3 operator datapath
//
// Purpose:
//   Free-running divider produces the sample-rate strobe. Each strobe taken
//   in IDLE sweeps every (bank, operator) slot through the operator pipeline,
//   SLOT_CYCLES clocks per slot. The scheduler then waits PIPELINE_DEPTH clocks
//   for the pipeline to drain and pulses ops_done on the last drain clock.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   sample_clk_en  out  one-clock pulse every CLK_DIV_COUNT clocks
//   slot_valid     out  first clock of each scheduled slot
//   bank_num       out  bank of the current slot
//   op_num         out  operator of the current slot
//   slot_phase     out  clock index within the current slot
//   busy           out  high while sweeping or draining
//   ops_done       out  one-clock pulse when the last slot has left the pipeline
//   overrun        out  sticky: a strobe arrived while busy
//
// Build option:
//   OPL3_SCHED_OVERRUN_DETECT_EN - when defined, builds the overrun detector;
//   otherwise overrun is tied to 0.
//
// All outputs come straight from flops.

module opl3_slot_scheduler #(
    parameter int CLK_DIV_COUNT    = 512,
    parameter int NUM_BANKS        = 2,
    parameter int NUM_OPS_PER_BANK = 18,
    parameter int SLOT_CYCLES      = 4,
    parameter int PIPELINE_DEPTH   = 8,
    localparam int BANK_W  = (NUM_BANKS > 1)        ? $clog2(NUM_BANKS)        : 1,
    localparam int OP_W    = (NUM_OPS_PER_BANK > 1) ? $clog2(NUM_OPS_PER_BANK) : 1,
    localparam int PHASE_W = (SLOT_CYCLES > 1)      ? $clog2(SLOT_CYCLES)      : 1
) (
    input  logic               clk,
    input  logic               reset,
    output logic               sample_clk_en,
    output logic               slot_valid,
    output logic [BANK_W-1:0]  bank_num,
    output logic [OP_W-1:0]    op_num,
    output logic [PHASE_W-1:0] slot_phase,
    output logic               busy,
    output logic               ops_done,
    output logic               overrun
);

    localparam int DIV_W   = $clog2(CLK_DIV_COUNT);
    localparam int DRAIN_W = (PIPELINE_DEPTH > 1) ? $clog2(PIPELINE_DEPTH) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV_COUNT - 1);
    localparam logic [DIV_W-1:0]   DIV_PRE    = DIV_W'(CLK_DIV_COUNT - 2);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SLOT_CYCLES - 1);
    localparam logic [OP_W-1:0]    OP_LAST    = OP_W'(NUM_OPS_PER_BANK - 1);
    localparam logic [BANK_W-1:0]  BANK_LAST  = BANK_W'(NUM_BANKS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPELINE_DEPTH - 1);
    localparam logic               DRAIN_ONE  = (PIPELINE_DEPTH == 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Sample-rate divider (free running, independent of the FSM)
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_sample_clk_en;

    // The strobe flop is loaded one count early so that it is high on
    // exactly the clock where the counter reads CLK_DIV_COUNT-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt       <= '0;
            r_sample_clk_en <= 1'b0;
        end else begin
            r_div_cnt       <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
            r_sample_clk_en <= (r_div_cnt == DIV_PRE);
        end
    end

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [BANK_W-1:0]  r_bank;
    logic [OP_W-1:0]    r_op;
    logic [PHASE_W-1:0] r_phase;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic               r_slot_valid;
    logic               r_busy;
    logic               r_ops_done;

    state_t             w_state_nxt;
    logic [BANK_W-1:0]  w_bank_nxt;
    logic [OP_W-1:0]    w_op_nxt;
    logic [PHASE_W-1:0] w_phase_nxt;
    logic [DRAIN_W-1:0] w_drain_nxt;
    logic [DRAIN_W-1:0] w_drain_inc;
    logic               w_slot_valid_nxt;
    logic               w_busy_nxt;
    logic               w_ops_done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_bank       <= '0;
            r_op         <= '0;
            r_phase      <= '0;
            r_drain_cnt  <= '0;
            r_slot_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_ops_done   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bank       <= w_bank_nxt;
            r_op         <= w_op_nxt;
            r_phase      <= w_phase_nxt;
            r_drain_cnt  <= w_drain_nxt;
            r_slot_valid <= w_slot_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_ops_done   <= w_ops_done_nxt;
        end
    end

    // Next-state logic computes the values the output flops will show on
    // the following clock, so slot_valid/busy/ops_done line up with the
    // state they describe without any combinational output decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_bank_nxt       = r_bank;
        w_op_nxt         = r_op;
        w_phase_nxt      = r_phase;
        w_drain_nxt      = r_drain_cnt;
        w_drain_inc      = r_drain_cnt + DRAIN_W'(1);
        w_slot_valid_nxt = 1'b0;
        w_busy_nxt       = 1'b0;
        w_ops_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_bank_nxt  = '0;
                w_op_nxt    = '0;
                w_phase_nxt = '0;
                w_drain_nxt = '0;
                if (r_sample_clk_en) begin
                    w_state_nxt      = S_SWEEP;
                    w_slot_valid_nxt = 1'b1;
                    w_busy_nxt       = 1'b1;
                end
            end

            S_SWEEP: begin
                w_busy_nxt = 1'b1;
                if (r_phase == PHASE_LAST) begin
                    w_phase_nxt = '0;
                    if (r_op == OP_LAST) begin
                        w_op_nxt = '0;
                        if (r_bank == BANK_LAST) begin
                            // Last slot issued: counters park at 0 for DRAIN.
                            w_bank_nxt     = '0;
                            w_state_nxt    = S_DRAIN;
                            w_drain_nxt    = '0;
                            w_ops_done_nxt = DRAIN_ONE;
                        end else begin
                            w_bank_nxt       = r_bank + BANK_W'(1);
                            w_slot_valid_nxt = 1'b1;
                        end
                    end else begin
                        w_op_nxt         = r_op + OP_W'(1);
                        w_slot_valid_nxt = 1'b1;
                    end
                end else begin
                    w_phase_nxt = r_phase + PHASE_W'(1);
                end
            end

            S_DRAIN: begin
                // Strobes are ignored here; the DRAIN->IDLE step consumes any
                // strobe coinciding with ops_done without starting a sweep.
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_drain_nxt = '0;
                end else begin
                    w_drain_nxt    = w_drain_inc;
                    w_busy_nxt     = 1'b1;
                    w_ops_done_nxt = (w_drain_inc == DRAIN_LAST);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_bank_nxt  = '0;
                w_op_nxt    = '0;
                w_phase_nxt = '0;
                w_drain_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Overrun detection
    // ------------------------------------------------------------------
`ifdef OPL3_SCHED_OVERRUN_DETECT_EN
    logic r_overrun;

    // r_busy is exactly the busy output, so this flags a strobe seen
    // while a sweep or drain is in progress. Sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (r_sample_clk_en && r_busy) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

    assign sample_clk_en = r_sample_clk_en;
    assign slot_valid    = r_slot_valid;
    assign bank_num      = r_bank;
    assign op_num        = r_op;
    assign slot_phase    = r_phase;
    assign busy          = r_busy;
    assign ops_done      = r_ops_done;

endmodule

// File: tb/tb_opl3_slot_scheduler.sv
// tb/tb_opl3_slot_scheduler.sv - directed table-driven bench for opl3_slot_scheduler

module tb_opl3_slot_scheduler;

    typedef struct packed {
        logic       en;
        logic       sv;
        logic       bank;
        logic [4:0] op;
        logic [1:0] ph;
        logic       busy;
        logic       done;
        logic       ovr;
    } obs_t;

    typedef struct {
        string name;
        int    dut;
        int    cyc;
        obs_t  exp;
        obs_t  mask;
    } vec_t;

    localparam int RUN = 340;

`ifdef OPL3_SCHED_OVERRUN_DETECT_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_a;
    logic rst_bcd;

    always #5 clk = ~clk;

    logic       en_a, sv_a, bank_a, ph_a, busy_a, done_a, ovr_a;
    logic [4:0] op_a;
    logic       en_b, sv_b, bank_b, busy_b, done_b, ovr_b;
    logic [4:0] op_b;
    logic [1:0] ph_b;
    logic       en_c, sv_c, bank_c, ph_c, busy_c, done_c, ovr_c;
    logic [4:0] op_c;
    logic       en_d, sv_d, bank_d, ph_d, busy_d, done_d, ovr_d;
    logic [4:0] op_d;

    // A: basic sweep + mid-sweep reset
    opl3_slot_scheduler #(.CLK_DIV_COUNT(64), .NUM_BANKS(2), .NUM_OPS_PER_BANK(18),
                          .SLOT_CYCLES(1), .PIPELINE_DEPTH(8)) dut_a (
        .clk(clk), .reset(rst_a), .sample_clk_en(en_a), .slot_valid(sv_a),
        .bank_num(bank_a), .op_num(op_a), .slot_phase(ph_a), .busy(busy_a),
        .ops_done(done_a), .overrun(ovr_a));

    // B: four clocks per slot
    opl3_slot_scheduler #(.CLK_DIV_COUNT(160), .NUM_BANKS(2), .NUM_OPS_PER_BANK(18),
                          .SLOT_CYCLES(4), .PIPELINE_DEPTH(8)) dut_b (
        .clk(clk), .reset(rst_bcd), .sample_clk_en(en_b), .slot_valid(sv_b),
        .bank_num(bank_b), .op_num(op_b), .slot_phase(ph_b), .busy(busy_b),
        .ops_done(done_b), .overrun(ovr_b));

    // C: second strobe lands mid-drain
    opl3_slot_scheduler #(.CLK_DIV_COUNT(40), .NUM_BANKS(2), .NUM_OPS_PER_BANK(18),
                          .SLOT_CYCLES(1), .PIPELINE_DEPTH(8)) dut_c (
        .clk(clk), .reset(rst_bcd), .sample_clk_en(en_c), .slot_valid(sv_c),
        .bank_num(bank_c), .op_num(op_c), .slot_phase(ph_c), .busy(busy_c),
        .ops_done(done_c), .overrun(ovr_c));

    // D: strobe period equals sweep+drain, so every later strobe lands on ops_done
    opl3_slot_scheduler #(.CLK_DIV_COUNT(44), .NUM_BANKS(2), .NUM_OPS_PER_BANK(18),
                          .SLOT_CYCLES(1), .PIPELINE_DEPTH(8)) dut_d (
        .clk(clk), .reset(rst_bcd), .sample_clk_en(en_d), .slot_valid(sv_d),
        .bank_num(bank_d), .op_num(op_d), .slot_phase(ph_d), .busy(busy_d),
        .ops_done(done_d), .overrun(ovr_d));

    obs_t logs [0:3][0:RUN];
    int   n_vec = 0;
    int   n_bad = 0;

    obs_t m_full, m_core, m_done, m_en, m_ovr, m_act;

    function automatic obs_t mk(logic en, logic sv, logic bank, logic [4:0] op,
                                logic [1:0] ph, logic busy, logic done, logic ovr);
        obs_t o;
        o.en = en; o.sv = sv; o.bank = bank; o.op = op;
        o.ph = ph; o.busy = busy; o.done = done; o.ovr = ovr;
        return o;
    endfunction

    function automatic vec_t mkv(string n, int d, int c, obs_t e, obs_t m);
        vec_t v;
        v.name = n; v.dut = d; v.cyc = c; v.exp = e; v.mask = m;
        return v;
    endfunction

    // Expected core outputs rel clocks after a strobe taken in IDLE
    // (2 banks x 18 operators, drain depth 8).
    function automatic obs_t sweep_exp(int rel, int sc);
        obs_t o;
        int   s;
        int   k;
        int   ph;
        o = '0;
        s = 36 * sc;
        if (rel >= 1 && rel <= s) begin
            k      = (rel - 1) / sc;
            ph     = (rel - 1) % sc;
            o.sv   = (ph == 0);
            o.bank = (k >= 18);
            o.op   = 5'(k % 18);
            o.ph   = 2'(ph);
            o.busy = 1'b1;
        end else if (rel > s && rel <= s + 8) begin
            o.busy = 1'b1;
            o.done = (rel == s + 8);
        end
        return o;
    endfunction

    task automatic capture(int c);
        logs[0][c] = mk(en_a, sv_a, bank_a, op_a, {1'b0, ph_a}, busy_a, done_a, ovr_a);
        logs[1][c] = mk(en_b, sv_b, bank_b, op_b, ph_b,         busy_b, done_b, ovr_b);
        logs[2][c] = mk(en_c, sv_c, bank_c, op_c, {1'b0, ph_c}, busy_c, done_c, ovr_c);
        logs[3][c] = mk(en_d, sv_d, bank_d, op_d, {1'b0, ph_d}, busy_d, done_d, ovr_d);
    endtask

    task automatic chk(string name, int d, int c, obs_t e, obs_t m);
        obs_t a;
        a = logs[d][c];
        n_vec++;
        if (((a ^ e) & m) != '0) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc %0d: got %b, expected %b (mask %b)",
                     name, d, c, a, e, m);
        end
    endtask

    task automatic sweep_chk(string name, int d, int t, int sc);
        for (int r = 1; r <= 36 * sc + 9; r++)
            chk(name, d, t + r, sweep_exp(r, sc), m_core);
    endtask

    vec_t vt[$];

    initial begin
        rst_a   = 1'b1;
        rst_bcd = 1'b1;

        m_full = '1;
        m_core = '1; m_core.en = 1'b0; m_core.ovr = 1'b0;
        m_done = '0; m_done.done = 1'b1;
        m_en   = '0; m_en.en = 1'b1;
        m_ovr  = '0; m_ovr.ovr = 1'b1;
        m_act  = '0; m_act.sv = 1'b1; m_act.busy = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst_a   = 1'b0;
        rst_bcd = 1'b0;
        capture(0);

        // Cycle c = c-th rising edge after reset release, sampled 1 unit later.
        for (int c = 1; c <= RUN; c++) begin
            @(posedge clk);
            #1;
            capture(c);
            if (c == 138) rst_a = 1'b1;   // A is at slot (0,10) now
            if (c == 139) rst_a = 1'b0;
        end

        // name, dut, cycle, {en,sv,bank,op,ph,busy,done,ovr}, mask
        vt.push_back(mkv("rst_a",       0,   0, mk(0,0,0, 0,0,0,0,0), m_full));
        vt.push_back(mkv("rst_b",       1,   0, mk(0,0,0, 0,0,0,0,0), m_full));
        vt.push_back(mkv("rst_c",       2,   0, mk(0,0,0, 0,0,0,0,0), m_full));
        vt.push_back(mkv("rst_d",       3,   0, mk(0,0,0, 0,0,0,0,0), m_full));
        vt.push_back(mkv("a_first_en",  0,  63, mk(1,0,0, 0,0,0,0,0), m_full));
        vt.push_back(mkv("a_idle_126",  0, 126, mk(0,0,0, 0,0,0,0,0), m_full));
        vt.push_back(mkv("a_second_en", 0, 127, mk(1,0,0, 0,0,0,0,0), m_full));
        vt.push_back(mkv("a_slot_0_10", 0, 138, mk(0,1,0,10,0,1,0,0), m_full));
        vt.push_back(mkv("a_rst_mid",   0, 139, mk(0,0,0, 0,0,0,0,0), m_full));
        vt.push_back(mkv("a_rst_en",    0, 202, mk(1,0,0, 0,0,0,0,0), m_full));
        vt.push_back(mkv("a_clean",     0, 203, mk(0,1,0, 0,0,1,0,0), m_full));
        vt.push_back(mkv("a_done2",     0, 246, mk(0,0,0, 0,0,1,1,0), m_full));
        vt.push_back(mkv("b_en",        1, 159, mk(1,0,0, 0,0,0,0,0), m_full));
        vt.push_back(mkv("b_ph1",       1, 161, mk(0,0,0, 0,1,1,0,0), m_full));
        vt.push_back(mkv("b_op1",       1, 164, mk(0,1,0, 1,0,1,0,0), m_full));
        vt.push_back(mkv("b_last",      1, 303, mk(0,0,1,17,3,1,0,0), m_full));
        vt.push_back(mkv("b_done",      1, 311, mk(0,0,0, 0,0,1,1,0), m_full));
        vt.push_back(mkv("b_idle",      1, 312, mk(0,0,0, 0,0,0,0,0), m_full));
        vt.push_back(mkv("c_en_drain",  2,  79, mk(1,0,0, 0,0,1,0,0), m_full));
        vt.push_back(mkv("c_ovr_set",   2,  80, mk(0,0,0, 0,0,1,0,OVR_EXP), m_full));
        vt.push_back(mkv("c_done",      2,  83, mk(0,0,0, 0,0,1,1,OVR_EXP), m_full));
        vt.push_back(mkv("c_idle",      2,  84, mk(0,0,0, 0,0,0,0,OVR_EXP), m_full));
        vt.push_back(mkv("c_sweep2",    2, 120, mk(0,1,0, 0,0,1,0,OVR_EXP), m_full));
        vt.push_back(mkv("c_sticky",    2, 300, mk(0,0,0, 0,0,0,0,OVR_EXP), m_ovr));
        vt.push_back(mkv("d_coincide",  3,  87, mk(1,0,0, 0,0,1,1,0), m_full));
        vt.push_back(mkv("d_no_start",  3,  88, mk(0,0,0, 0,0,0,0,OVR_EXP), m_full));
        vt.push_back(mkv("d_third_en",  3, 131, mk(1,0,0, 0,0,0,0,OVR_EXP), m_full));
        vt.push_back(mkv("d_sweep",     3, 132, mk(0,1,0, 0,0,1,0,OVR_EXP), m_full));

        foreach (vt[i])
            chk(vt[i].name, vt[i].dut, vt[i].cyc, vt[i].exp, vt[i].mask);

        // Quiet until the first strobe, and strobes only every 64 clocks.
        for (int c = 1; c <= 62; c++)
            chk("a_pre_quiet", 0, c, '0, m_full);
        for (int c = 1; c <= 138; c++)
            chk("a_period", 0, c, mk((c == 63) || (c == 127), 0,0,0,0,0,0,0), m_en);

        // Full sweep timelines.
        sweep_chk("a_sweep1", 0,  63, 1);
        sweep_chk("a_sweep3", 0, 202, 1);
        sweep_chk("b_sweep",  1, 159, 4);
        sweep_chk("c_sweep",  2,  39, 1);
        sweep_chk("d_sweep1", 3,  43, 1);
        sweep_chk("d_sweep2", 3, 131, 1);

        // Aborted sweep never reports completion.
        for (int c = 139; c <= 245; c++)
            chk("a_abort_no_done", 0, c, '0, m_done);

        // Coinciding strobe leaves D idle until the next one.
        for (int c = 88; c <= 130; c++)
            chk("d_stay_idle", 3, c, '0, m_act);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
